unified_mem_arbiter: RTL and testbench

//   Shares one single-ported unified memory between the pipeline's IF stage (instruction fetch) and MEM stage (load/store).

---
 rtl/unified_mem_arbiter_pkg.sv | 13 +
 rtl/unified_mem_arbiter_timeout_ctr.sv | 27 ++
 rtl/unified_mem_arbiter.sv | 119 +++++++++++
 tb/tb_unified_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and the I/D arbitration decision for the unified memory arbiter.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  // The data side wins unless a fetch is waiting and D has already used its streak.
  function automatic owner_t arb_pick(input logic i_req, input logic d_req,
                                      input logic streak_full);
    return (d_req && (!i_req || !streak_full)) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_timeout_ctr.sv
// Response watchdog: counts cycles spent waiting on memory, flags TIMEOUT-1 reached.
module arb_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && !expired)
      count <= count + 1'b1;
  end

  assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates IF and MEM accesses onto one single-ported memory, one transaction at a time.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 3,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err
);

  localparam int STREAK_W = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;

  arb_state_t          state;
  owner_t              owner;
  owner_t              pick;
  logic [STREAK_W-1:0] streak;
  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic [DATA_W-1:0]   resp_data;
  logic                expired;
  logic                done;

  function automatic logic [STREAK_W-1:0] streak_sat_inc(input logic [STREAK_W-1:0] s);
    return (s >= STREAK_W'(MAX_D_STREAK)) ? s : s + 1'b1;
  endfunction

  assign pick = arb_pick(i_req, d_req, streak >= STREAK_W'(MAX_D_STREAK));

  arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != BUSY),
    .enable  (state == BUSY),
    .expired (expired)
  );

  // Completion is combinational with the response so ready lands in the response cycle;
  // a timeout completes with zero data.
  assign done      = (state == BUSY) && (mem_resp_valid || expired);
  assign resp_data = mem_resp_valid ? mem_rdata : '0;
  assign i_ready   = done && (owner == OWN_I);
  assign d_ready   = done && (owner == OWN_D);
  assign i_rdata   = i_ready ? resp_data : i_rdata_q;
  assign d_rdata   = d_ready ? resp_data : d_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= OWN_I;
      streak      <= '0;
      mem_valid   <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!i_req || pick == OWN_I)
            streak <= '0;
          else
            streak <= streak_sat_inc(streak);
          if (i_req || d_req) begin
            owner     <= pick;
            mem_valid <= 1'b1;
            state     <= ISSUE;
            if (pick == OWN_D) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= i_addr;
            end
          end
        end
        ISSUE: begin
          mem_valid <= 1'b0;
          state     <= BUSY;
        end
        BUSY: begin
          if (done) begin
            state <= IDLE;
            if (owner == OWN_I)
              i_rdata_q <= resp_data;
            else
              d_rdata_q <= resp_data;
            if (!mem_resp_valid)
              timeout_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus a randomized run against a transaction model.
module tb_unified_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MAX_D  = 3;
  localparam int TMO    = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              i_req, d_req, d_we, mem_resp_valid;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [DATA_W-1:0] d_wdata, mem_rdata;
  logic              i_ready, d_ready, mem_valid, mem_we, timeout_err;
  logic [DATA_W-1:0] i_rdata, d_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;

  unified_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_D_STREAK(MAX_D), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_resp_valid = 0; mem_rdata = '0;
  endtask

  // randomized-phase model state
  logic        ip, dp, dwe, p_free, cur_free, p_i, p_d, p_dwe, p_irdy, p_drdy, own_d, exp_d, raise_en;
  logic [31:0] ia, da, dw, p_ia, p_da, p_dw, rd_exp, last_i, last_d;
  int          streak_m, resp_at, n_grant;

  // scenario locals
  int          got[8];
  int          ng, wr_cnt, mv_cnt, dr_cnt, ir_cnt, mv_at, mv5, rd5, s_m, e_d;
  logic        resp_due;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();

    // 1: reset values, then 20 quiet cycles with a stray response in IDLE
    repeat (3) nxt();
    #1;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_iready", i_ready, 0);
    chk("rst_dready", d_ready, 0);
    chk("rst_timeout", timeout_err, 0);
    reset = 1;
    for (int k = 0; k < 20; k++) begin
      nxt();
      mem_resp_valid = (k == 5);
      mem_rdata = (k == 5) ? 32'hFFFF_FFFF : 32'h0;
      #1;
      chk("t1_mem_valid", mem_valid, 0);
      chk("t1_iready", i_ready, 0);
      chk("t1_dready", d_ready, 0);
    end
    chk("t1_i_rdata", i_rdata, 0);
    chk("t1_d_rdata", d_rdata, 0);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_mem_addr", mem_addr, 0);
    chk("t1_mem_wdata", mem_wdata, 0);
    chk("t1_timeout", timeout_err, 0);

    // 2: single fetch, response two cycles after mem_valid; stray strobe during ISSUE
    nxt(); idle_inputs(); i_req = 1; i_addr = 32'h10; #1;
    chk("t2_mv_t0", mem_valid, 0);
    nxt(); mem_resp_valid = 1; mem_rdata = 32'hBAD0_BAD0; #1;
    chk("t2_mv_t1", mem_valid, 1);
    chk("t2_addr", mem_addr, 32'h10);
    chk("t2_we", mem_we, 0);
    chk("t2_issue_stray", i_ready, 0);
    nxt(); mem_resp_valid = 0; #1;
    chk("t2_mv_t2", mem_valid, 0);
    chk("t2_iready_t2", i_ready, 0);
    nxt(); mem_resp_valid = 1; mem_rdata = 32'h0050_0093; #1;
    chk("t2_iready_t3", i_ready, 1);
    chk("t2_i_rdata", i_rdata, 32'h0050_0093);
    chk("t2_dready_t3", d_ready, 0);
    nxt(); idle_inputs(); #1;
    chk("t2_iready_t4", i_ready, 0);
    chk("t2_i_rdata_held", i_rdata, 32'h0050_0093);

    // 3: both requesters always pending, latency 1
    ng = 0; resp_due = 0;
    for (int k = 0; k < 200; k++) begin
      nxt();
      i_req = 1; i_addr = 32'h1000; d_req = 1; d_we = 0; d_addr = 32'h2000;
      mem_resp_valid = resp_due; mem_rdata = 32'hC0DE_0000 + k; resp_due = 0;
      #1;
      if (mem_valid) begin
        if (ng < 8) got[ng] = (mem_addr == 32'h2000) ? 1 : 0;
        ng++;
        resp_due = 1;
      end
      chk("t3_excl", i_ready & d_ready, 0);
      if ((i_ready || d_ready) && ng >= 8) break;
    end
    chk("t3_ngrant", ng, 8);
    s_m = 0;
    for (int k = 0; k < 8; k++) begin
      if (s_m < MAX_D) begin e_d = 1; s_m++; end
      else begin e_d = 0; s_m = 0; end
      chk($sformatf("t3_order%0d", k), got[k], e_d);
    end

    // 4: single store
    wr_cnt = 0; mv_cnt = 0; dr_cnt = 0; ir_cnt = 0; mv_at = -100;
    for (int k = 0; k < 20; k++) begin
      nxt();
      i_req = 0; d_req = (dr_cnt == 0); d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
      mem_resp_valid = (cyc_n == mv_at + 2); mem_rdata = 32'h1234_5678;
      #1;
      if (mem_valid) begin
        mv_at = cyc_n; mv_cnt++;
        if (mem_we && mem_wdata == 32'hDEAD_BEEF && mem_addr == 32'h200) wr_cnt++;
      end
      dr_cnt += d_ready;
      ir_cnt += i_ready;
    end
    chk("t4_mv_cnt", mv_cnt, 1);
    chk("t4_wr_cnt", wr_cnt, 1);
    chk("t4_dready_cnt", dr_cnt, 1);
    chk("t4_iready_cnt", ir_cnt, 0);

    // 5: timeout on a load, then a normal fetch
    chk("t5_err_pre", timeout_err, 0);
    mv5 = -1; rd5 = -1;
    for (int k = 0; k < 100; k++) begin
      nxt();
      idle_inputs(); d_req = (rd5 < 0); d_we = 0; d_addr = 32'h300;
      #1;
      if (mem_valid) mv5 = cyc_n;
      if (d_ready) begin
        rd5 = cyc_n;
        chk("t5_rdata_zero", d_rdata, 0);
      end
      chk("t5_iready", i_ready, 0);
      if (rd5 >= 0) break;
    end
    chk("t5_latency", rd5 - mv5, TMO);
    nxt(); idle_inputs(); #1;
    chk("t5_err_set", timeout_err, 1);
    chk("t5_d_rdata_held", d_rdata, 0);
    ir_cnt = 0; resp_due = 0;
    for (int k = 0; k < 20; k++) begin
      nxt();
      idle_inputs(); i_req = (ir_cnt == 0); i_addr = 32'h400;
      mem_resp_valid = resp_due; mem_rdata = 32'hA5A5_0001; resp_due = 0;
      #1;
      if (mem_valid) resp_due = 1;
      if (i_ready) begin
        ir_cnt++;
        chk("t5_next_rdata", i_rdata, 32'hA5A5_0001);
      end
    end
    chk("t5_next_served", ir_cnt, 1);
    chk("t5_err_sticky", timeout_err, 1);

    // randomized traffic against a transaction-level model
    nxt(); idle_inputs(); #1;
    ip = 0; dp = 0; dwe = 0; ia = 0; da = 0; dw = 0;
    p_free = 1; p_i = 0; p_d = 0; p_dwe = 0; p_ia = 0; p_da = 0; p_dw = 0;
    p_irdy = 0; p_drdy = 0; own_d = 0; streak_m = 0; resp_at = -1; n_grant = 0;
    last_i = 32'hA5A5_0001; last_d = 32'h0;
    for (int k = 0; k < 420; k++) begin
      raise_en = (k < 400);
      nxt();
      if (p_irdy) ip = 0;
      if (p_drdy) dp = 0;
      if (raise_en && !ip && $urandom_range(0, 2) == 0) begin ip = 1; ia = $urandom; end
      if (raise_en && !dp && $urandom_range(0, 2) == 0) begin
        dp = 1; da = $urandom; dw = $urandom; dwe = 1'($urandom_range(0, 1));
      end
      i_req = ip; i_addr = ia; d_req = dp; d_addr = da; d_wdata = dw; d_we = dwe;
      mem_resp_valid = (cyc_n == resp_at);
      rd_exp = $urandom;
      mem_rdata = mem_resp_valid ? rd_exp : 32'($urandom);
      #1;
      cur_free = (p_free && !mem_valid) || p_irdy || p_drdy;
      if (p_free) begin
        if (mem_valid) begin
          exp_d = p_d && (!p_i || streak_m < MAX_D);
          chk("rnd_addr", mem_addr, exp_d ? p_da : p_ia);
          chk("rnd_we", mem_we, exp_d & p_dwe);
          if (exp_d) chk("rnd_wdata", mem_wdata, p_dw);
          if (!p_i || !exp_d) streak_m = 0;
          else if (streak_m < MAX_D) streak_m++;
          own_d = exp_d;
          resp_at = cyc_n + $urandom_range(1, 4);
          n_grant++;
        end else begin
          chk("rnd_nogrant", p_i | p_d, 0);
          streak_m = 0;
        end
      end else begin
        chk("rnd_mv_spurious", mem_valid, 0);
      end
      chk("rnd_iready", i_ready, (cyc_n == resp_at) && !own_d);
      chk("rnd_dready", d_ready, (cyc_n == resp_at) && own_d);
      if (cyc_n == resp_at) begin
        if (own_d) last_d = rd_exp;
        else last_i = rd_exp;
      end
      chk("rnd_i_rdata", i_rdata, last_i);
      chk("rnd_d_rdata", d_rdata, last_d);
      p_free = cur_free; p_i = i_req; p_d = d_req;
      p_ia = ia; p_da = da; p_dw = dw; p_dwe = dwe;
      p_irdy = i_ready; p_drdy = d_ready;
    end
    chk("rnd_drained", ip | dp, 0);
    chk("rnd_enough_grants", n_grant > 20, 1);

    // 6: reset in the middle of BUSY, then a stray late response
    nxt(); idle_inputs(); i_req = 1; i_addr = 32'h500; #1;
    nxt(); #1;
    chk("t6_mv", mem_valid, 1);
    nxt(); #1;
    nxt(); #1;
    #2; reset = 0; #1;
    chk("t6_rst_mv", mem_valid, 0);
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_we", mem_we, 0);
    chk("t6_rst_wdata", mem_wdata, 0);
    chk("t6_rst_iready", i_ready, 0);
    chk("t6_rst_i_rdata", i_rdata, 0);
    chk("t6_rst_d_rdata", d_rdata, 0);
    chk("t6_rst_timeout", timeout_err, 0);
    nxt(); i_req = 0; #1; reset = 1;
    nxt(); mem_resp_valid = 1; mem_rdata = 32'hFEED_FACE; #1;
    chk("t6_stray_iready", i_ready, 0);
    chk("t6_stray_dready", d_ready, 0);
    chk("t6_stray_i_rdata", i_rdata, 0);
    chk("t6_stray_mv", mem_valid, 0);
    nxt(); idle_inputs(); d_req = 1; d_addr = 32'h600; #1;
    chk("t6_idle_mv", mem_valid, 0);
    nxt(); #1;
    chk("t6_regrant_mv", mem_valid, 1);
    chk("t6_regrant_addr", mem_addr, 32'h600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
